game_state_ctrl: RTL and testbench

GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

---
 rtl/game_state_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_game_state_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/game_state_ctrl.sv
// Game flow controller: IDLE/PLAY/DYING/OVER sequencing, per-player lives,
// gomba kill score and frame-counted respawn timers.
module game_state_ctrl #(
  parameter int LIVES          = 3,
  parameter int RESPAWN_FRAMES = 60,
  parameter int GOMBA_FRAMES   = 120,
  parameter int GOMBA_POINTS   = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_Clk,
  input  logic       start,
  input  logic       mario_dead,
  input  logic       luigi_dead,
  input  logic       gomba_dead,
  output logic [1:0] state,
  output logic       freeze,
  output logic [1:0] mario_lives,
  output logic [1:0] luigi_lives,
  output logic [7:0] score,
  output logic       mario_respawn,
  output logic       luigi_respawn,
  output logic       gomba_respawn,
  output logic       game_over
);
  typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, DYING = 2'b10, OVER = 2'b11} state_t;

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic [7:0] RESP_LD    = 8'(RESPAWN_FRAMES);
  localparam logic [7:0] GOMBA_LD   = 8'(GOMBA_FRAMES);
  localparam logic [8:0] PTS        = 9'(GOMBA_POINTS);

  state_t     state_q, state_d;
  logic [7:0] fcnt_q, fcnt_d, gcnt_q, gcnt_d, score_q, score_d;
  logic [1:0] mlives_q, mlives_d, llives_q, llives_d;
  logic       mpend_q, mpend_d, lpend_q, lpend_d;
  logic       mresp_q, mresp_d, lresp_q, lresp_d, gresp_q, gresp_d;
  logic       freeze_q, freeze_d, over_q, over_d;
  logic       frame_prev_q, start_prev_q, md_prev_q, ld_prev_q, gd_prev_q;
  logic       tick, start_e, md_e, ld_e, gd_e, md_ok, ld_ok;
  logic [8:0] score_sum;

  assign tick      = frame_Clk  & ~frame_prev_q;
  assign start_e   = start      & ~start_prev_q;
  assign md_e      = mario_dead & ~md_prev_q;
  assign ld_e      = luigi_dead & ~ld_prev_q;
  assign gd_e      = gomba_dead & ~gd_prev_q;
  assign md_ok     = md_e & (mlives_q != 2'd0);
  assign ld_ok     = ld_e & (llives_q != 2'd0);
  assign score_sum = {1'b0, score_q} + PTS;

  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    gcnt_d   = gcnt_q;
    score_d  = score_q;
    mlives_d = mlives_q;
    llives_d = llives_q;
    mpend_d  = mpend_q;
    lpend_d  = lpend_q;
    mresp_d  = 1'b0;
    lresp_d  = 1'b0;
    gresp_d  = 1'b0;
    case (state_q)
      IDLE: begin
        mlives_d = LIVES_INIT;
        llives_d = LIVES_INIT;
        score_d  = 8'd0;
        gcnt_d   = 8'd0;
        fcnt_d   = 8'd0;
        mpend_d  = 1'b0;
        lpend_d  = 1'b0;
        if (start_e) begin
          state_d = PLAY;
          mresp_d = 1'b1;
          lresp_d = 1'b1;
          gresp_d = 1'b1;
        end
      end
      PLAY, DYING: begin
        if (md_ok) begin
          mlives_d = mlives_q - 2'd1;
          mpend_d  = 1'b1;
        end
        if (ld_ok) begin
          llives_d = llives_q - 2'd1;
          lpend_d  = 1'b1;
        end
        if (gd_e) begin
          score_d = score_sum[8] ? 8'hFF : score_sum[7:0];
          if (gcnt_q == 8'd0) gcnt_d = GOMBA_LD;
        end
        if (state_q == PLAY) begin
          // gomba timer only runs while sprites move
          if (tick && gcnt_q != 8'd0) begin
            gcnt_d  = gcnt_q - 8'd1;
            gresp_d = (gcnt_q == 8'd1);
          end
          if (md_ok || ld_ok) begin
            state_d = DYING;
            fcnt_d  = RESP_LD;
          end
        end else if (tick && fcnt_q != 8'd0) begin
          fcnt_d = fcnt_q - 8'd1;
          if (fcnt_q == 8'd1) begin
            mpend_d = 1'b0;
            lpend_d = 1'b0;
            if (mlives_d == 2'd0 && llives_d == 2'd0) begin
              state_d = OVER;
            end else begin
              state_d = PLAY;
              mresp_d = mpend_d_any(md_ok, mpend_q) && (mlives_d != 2'd0);
              lresp_d = mpend_d_any(ld_ok, lpend_q) && (llives_d != 2'd0);
            end
          end
        end
      end
      OVER: begin
        if (start_e) begin
          state_d  = IDLE;
          mlives_d = LIVES_INIT;
          llives_d = LIVES_INIT;
          score_d  = 8'd0;
        end
      end
      default: state_d = IDLE;
    endcase
    freeze_d = (state_d != PLAY);
    over_d   = (state_d == OVER);
  end

  // pending includes a death that lands on the same cycle the timer expires
  function automatic logic mpend_d_any(input logic now, input logic held);
    return now | held;
  endfunction

  always_ff @(posedge Clk) begin
    frame_prev_q <= frame_Clk;
    start_prev_q <= start;
    md_prev_q    <= mario_dead;
    ld_prev_q    <= luigi_dead;
    gd_prev_q    <= gomba_dead;
    if (Reset) begin
      state_q  <= IDLE;
      fcnt_q   <= 8'd0;
      gcnt_q   <= 8'd0;
      score_q  <= 8'd0;
      mlives_q <= LIVES_INIT;
      llives_q <= LIVES_INIT;
      mpend_q  <= 1'b0;
      lpend_q  <= 1'b0;
      mresp_q  <= 1'b0;
      lresp_q  <= 1'b0;
      gresp_q  <= 1'b0;
      freeze_q <= 1'b1;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      fcnt_q   <= fcnt_d;
      gcnt_q   <= gcnt_d;
      score_q  <= score_d;
      mlives_q <= mlives_d;
      llives_q <= llives_d;
      mpend_q  <= mpend_d;
      lpend_q  <= lpend_d;
      mresp_q  <= mresp_d;
      lresp_q  <= lresp_d;
      gresp_q  <= gresp_d;
      freeze_q <= freeze_d;
      over_q   <= over_d;
    end
  end

  assign state         = state_q;
  assign freeze        = freeze_q;
  assign mario_lives   = mlives_q;
  assign luigi_lives   = llives_q;
  assign score         = score_q;
  assign mario_respawn = mresp_q;
  assign luigi_respawn = lresp_q;
  assign gomba_respawn = gresp_q;
  assign game_over     = over_q;
endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: rule-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_game_state_ctrl;
  localparam int LIVES = 3, RF = 60, GF = 120, GP = 1;

  logic Clk = 0, Reset = 1;
  logic frame_Clk = 0, start = 0, mario_dead = 0, luigi_dead = 0, gomba_dead = 0;
  logic [1:0] state, mario_lives, luigi_lives;
  logic [7:0] score;
  logic freeze, mario_respawn, luigi_respawn, gomba_respawn, game_over;

  int n_chk = 0, n_fail = 0, pulse_cnt = 0;

  game_state_ctrl #(.LIVES(LIVES), .RESPAWN_FRAMES(RF), .GOMBA_FRAMES(GF), .GOMBA_POINTS(GP)) dut (
    .Clk(Clk), .Reset(Reset), .frame_Clk(frame_Clk), .start(start),
    .mario_dead(mario_dead), .luigi_dead(luigi_dead), .gomba_dead(gomba_dead),
    .state(state), .freeze(freeze), .mario_lives(mario_lives), .luigi_lives(luigi_lives),
    .score(score), .mario_respawn(mario_respawn), .luigi_respawn(luigi_respawn),
    .gomba_respawn(gomba_respawn), .game_over(game_over));

  always #5 Clk = ~Clk;

  task automatic cmp(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: game mode as a number, timers as "frames remaining".
  int  m_mode, m_ml, m_ll, m_sc, dying_left, gomba_left;
  bit  m_frz, m_go, m_mr, m_lr, m_gr, m_pend, l_pend;
  bit  p_f, p_s, p_m, p_l, p_g;

  always @(posedge Clk) begin
    bit tk, st, md, ld, gd, mok, lok;
    int g_was;
    if (Reset) begin
      m_mode = 0; m_ml = LIVES; m_ll = LIVES; m_sc = 0;
      dying_left = 0; gomba_left = 0; m_pend = 0; l_pend = 0;
      m_mr = 0; m_lr = 0; m_gr = 0;
    end else begin
      tk = frame_Clk && !p_f; st = start && !p_s;
      md = mario_dead && !p_m; ld = luigi_dead && !p_l; gd = gomba_dead && !p_g;
      m_mr = 0; m_lr = 0; m_gr = 0;
      if (m_mode == 0) begin
        m_ml = LIVES; m_ll = LIVES; m_sc = 0; gomba_left = 0; m_pend = 0; l_pend = 0;
        if (st) begin m_mode = 1; m_mr = 1; m_lr = 1; m_gr = 1; end
      end else if (m_mode == 3) begin
        if (st) begin m_mode = 0; m_ml = LIVES; m_ll = LIVES; m_sc = 0; end
      end else begin
        mok = md && m_ml > 0; lok = ld && m_ll > 0;
        if (mok) begin m_ml--; m_pend = 1; end
        if (lok) begin m_ll--; l_pend = 1; end
        g_was = gomba_left;
        if (gd) begin
          m_sc = (m_sc + GP > 255) ? 255 : m_sc + GP;
          if (g_was == 0) gomba_left = GF;
        end
        if (m_mode == 1) begin
          if (tk && g_was > 0) begin
            gomba_left = g_was - 1;
            m_gr = (gomba_left == 0);
          end
          if (mok || lok) begin m_mode = 2; dying_left = RF; end
        end else if (tk) begin
          dying_left--;
          if (dying_left == 0) begin
            if (m_ml == 0 && m_ll == 0) m_mode = 3;
            else begin
              m_mode = 1;
              m_mr = m_pend && m_ml > 0;
              m_lr = l_pend && m_ll > 0;
            end
            m_pend = 0; l_pend = 0;
          end
        end
      end
    end
    m_frz = (m_mode != 1); m_go = (m_mode == 3);
    p_f = frame_Clk; p_s = start; p_m = mario_dead; p_l = luigi_dead; p_g = gomba_dead;
  end

  // Cycle-by-cycle comparison against the model
  always @(posedge Clk) begin
    #1;
    cmp("state", int'(state), m_mode);
    cmp("freeze", int'(freeze), int'(m_frz));
    cmp("game_over", int'(game_over), int'(m_go));
    cmp("mario_lives", int'(mario_lives), m_ml);
    cmp("luigi_lives", int'(luigi_lives), m_ll);
    cmp("score", int'(score), m_sc);
    cmp("mario_respawn", int'(mario_respawn), int'(m_mr));
    cmp("luigi_respawn", int'(luigi_respawn), int'(m_lr));
    cmp("gomba_respawn", int'(gomba_respawn), int'(m_gr));
    if (mario_respawn || luigi_respawn || gomba_respawn) pulse_cnt++;
  end

  task automatic set_in(input int w, input logic v);
    case (w)
      0: start = v;
      1: mario_dead = v;
      2: luigi_dead = v;
      3: gomba_dead = v;
      default: frame_Clk = v;
    endcase
  endtask

  task automatic rise(input int w);
    @(negedge Clk); set_in(w, 1'b1); @(negedge Clk);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      @(negedge Clk); frame_Clk = 1;
      @(negedge Clk); frame_Clk = 0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge Clk);
    Reset = 0;
    @(negedge Clk);
    cmp("lit_reset_state", int'(state), 0);
    cmp("lit_reset_freeze", int'(freeze), 1);
    cmp("lit_reset_lives", int'({mario_lives, luigi_lives}), 4'b1111);
    cmp("lit_reset_score", int'(score), 0);

    // start: all three respawns for exactly one cycle
    rise(0);
    cmp("lit_start_state", int'(state), 1);
    cmp("lit_start_pulses", int'({mario_respawn, luigi_respawn, gomba_respawn}), 3'b111);
    set_in(0, 1'b0);
    @(negedge Clk);
    cmp("lit_start_pulse_len", int'({mario_respawn, luigi_respawn, gomba_respawn}), 0);

    // single death and 60-frame respawn
    rise(1);
    cmp("lit_mdeath_lives", int'(mario_lives), 2);
    cmp("lit_mdeath_state", int'(state), 2);
    cmp("lit_mdeath_freeze", int'(freeze), 1);
    set_in(1, 1'b0);
    frames(59);
    cmp("lit_dying_59", int'(state), 2);
    frames(1);
    cmp("lit_mresp", int'(mario_respawn), 1);
    cmp("lit_mresp_state", int'(state), 1);
    cmp("lit_mresp_freeze", int'(freeze), 0);

    // simultaneous deaths
    @(negedge Clk); mario_dead = 1; luigi_dead = 1;
    @(negedge Clk);
    cmp("lit_both_lives", int'({mario_lives, luigi_lives}), {2'd1, 2'd2});
    mario_dead = 0; luigi_dead = 0;
    frames(60);
    cmp("lit_both_resp", int'({mario_respawn, luigi_respawn}), 2'b11);

    // 300 kills saturate score; DYING frames don't advance the gomba timer
    repeat (300) begin rise(3); set_in(3, 1'b0); end
    cmp("lit_score_sat", int'(score), 255);
    frames(50);
    rise(2); set_in(2, 1'b0);
    frames(60);
    cmp("lit_lresp_mid", int'(luigi_respawn), 1);
    frames(69);
    cmp("lit_gomba_early", int'(gomba_respawn), 0);
    frames(1);
    cmp("lit_gomba_resp", int'(gomba_respawn), 1);

    // run lives down to game over
    rise(2); set_in(2, 1'b0);
    frames(60);
    cmp("lit_l0_state", int'(state), 1);
    cmp("lit_l0_noresp", int'(luigi_respawn), 0);
    rise(2); set_in(2, 1'b0);
    cmp("lit_ignore_zero_lives", int'(state), 1);
    rise(0); set_in(0, 1'b0);
    cmp("lit_ignore_start_play", int'(state), 1);
    rise(1); set_in(1, 1'b0);
    frames(60);
    cmp("lit_over_state", int'(state), 3);
    cmp("lit_over_flag", int'(game_over), 1);
    cmp("lit_over_noresp", int'({mario_respawn, luigi_respawn, gomba_respawn}), 0);
    cmp("lit_over_score", int'(score), 255);
    rise(0);
    cmp("lit_over_to_idle", int'(state), 0);
    cmp("lit_idle_lives", int'({mario_lives, luigi_lives}), 4'b1111);
    cmp("lit_idle_score", int'(score), 0);
    set_in(0, 1'b0);

    // reset in the middle of DYING with a gomba countdown active
    rise(0); set_in(0, 1'b0);
    rise(3); set_in(3, 1'b0);
    rise(1); set_in(1, 1'b0);
    frames(10);
    @(negedge Clk); Reset = 1;
    @(negedge Clk); @(negedge Clk); Reset = 0;
    @(negedge Clk);
    cmp("lit_rst_state", int'(state), 0);
    cmp("lit_rst_lives", int'({mario_lives, luigi_lives}), 4'b1111);
    pulse_cnt = 0;
    frames(130);
    cmp("lit_rst_no_pulse", pulse_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
